// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus bundle: PC-register control, instruction-memory handshake
// and the decode-facing instruction register. The fetch controller is the
// master; the surrounding PC register, memory and decode form the slave side.
interface fetch_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  // PC register control
  logic [XLEN-1:0]  pc_in;
  logic             take_branch;
  logic [XLEN-1:0]  branch_target;
  logic             stallF;
  // Redirect from execute
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_target;
  // Instruction memory
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [XLEN-1:0]  imem_rdata;
  // Decode side
  logic             instr_valid;
  logic [XLEN-1:0]  instr;
  logic [XLEN-1:0]  instr_pc;
  logic             instr_ready;
  // Performance monitor
  logic [CNT_W-1:0] squash_cnt;

  modport master (
    input  pc_in, redirect_valid, redirect_target,
           imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output take_branch, branch_target, stallF,
           imem_req, imem_addr, instr_valid, instr, instr_pc, squash_cnt
  );

  modport slave (
    output pc_in, redirect_valid, redirect_target,
           imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  take_branch, branch_target, stallF,
           imem_req, imem_addr, instr_valid, instr, instr_pc, squash_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: keeps one instruction-memory request in flight,
// buffers one fetched instruction for decode, and flushes/squashes on
// execute redirects while counting every discarded fetch.
module fetch_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic            drop;        // one stale response still to be discarded
  logic [XLEN-1:0] req_pc;      // address of the request in flight

  logic buf_free;
  logic req_ok;
  logic accept;
  logic resp;
  logic load;
  logic resp_drop;
  logic flush;

  // Handshake qualifiers shared by the datapath and the FSM
  always_comb begin
    buf_free  = !bus.instr_valid || bus.instr_ready;
    req_ok    = !rst && (state == S_REQ) && buf_free && !bus.redirect_valid;
    accept    = req_ok && bus.imem_gnt;
    // Responses are only meaningful while waiting; one arriving in S_REQ
    // (e.g. a late reply after reset) is ignored.
    resp      = (state == S_WAIT) && bus.imem_rvalid;
    load      = resp && !drop && !bus.redirect_valid;
    resp_drop = resp && (drop || bus.redirect_valid);
    flush     = bus.redirect_valid && bus.instr_valid;
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  // Next-state logic: leave S_REQ on a grant, leave S_WAIT on any response
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      S_REQ:  if (accept)          state_nxt = S_WAIT;
      S_WAIT: if (bus.imem_rvalid) state_nxt = S_REQ;
      default:                     state_nxt = S_REQ;
    endcase
  end

  // Output logic: memory request and PC-register control
  always_comb begin
    bus.imem_req      = req_ok;
    bus.imem_addr     = bus.pc_in;
    bus.take_branch   = !rst && bus.redirect_valid;
    bus.branch_target = {bus.redirect_target[XLEN-1:2], 2'b00};
    // PC moves on a grant (to PC+4) or on a redirect (to the target).
    bus.stallF        = rst || !(bus.redirect_valid || accept);
  end

  // Stale-response tracker: set by a redirect while a request is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop <= 1'b0;
    end else if (state == S_WAIT) begin
      if (bus.imem_rvalid)         drop <= 1'b0;
      else if (bus.redirect_valid) drop <= 1'b1;
    end
  end

  // Capture the address of each accepted request for tagging its response
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         req_pc <= '0;
    else if (accept) req_pc <= bus.pc_in;
  end

  // Decode output register: a load wins over consumption and flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.instr_valid <= 1'b0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
    end else if (load) begin
      bus.instr_valid <= 1'b1;
      bus.instr       <= bus.imem_rdata;
      bus.instr_pc    <= req_pc;
    end else if (bus.redirect_valid || bus.instr_ready) begin
      bus.instr_valid <= 1'b0;
    end
  end

  // Squash counter: buffer flush and response drop may both occur in a cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.squash_cnt <= '0;
    else     bus.squash_cnt <= bus.squash_cnt + CNT_W'(flush) + CNT_W'(resp_drop);
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a transaction-level model (queue of
// outstanding requests, one-entry decode buffer, squash tally) predicts the
// outputs every cycle; directed scenarios add hand-computed expectations.
module tb_fetch_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  fetch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } req_t;

  req_t        pend[$];     // requests granted but not yet answered
  bit          m_bv;        // decode buffer holds an instruction
  logic [31:0] m_bi;
  logic [31:0] m_bpc;
  logic [15:0] m_cnt;
  logic [31:0] pc_reg;      // external PC register driven by the DUT controls

  bit          e_req, e_stall, e_tb;
  logic [31:0] e_bt;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_bv  = 1'b0;
    m_bi  = '0;
    m_bpc = '0;
    m_cnt = '0;
  endtask

  task automatic predict();
    e_bt = {bus.redirect_target[31:2], 2'b00};
    if (rst) begin
      e_req   = 1'b0;
      e_stall = 1'b1;
      e_tb    = 1'b0;
    end else begin
      e_tb    = bus.redirect_valid;
      e_req   = (pend.size() == 0) && (!m_bv || bus.instr_ready) && !bus.redirect_valid;
      e_stall = !(bus.redirect_valid || (e_req && bus.imem_gnt));
    end
  endtask

  task automatic model_update();
    bit   redir = bus.redirect_valid;
    bit   old_bv = m_bv;
    bit   resp = bus.imem_rvalid && (pend.size() > 0);
    req_t e;
    if (old_bv && (bus.instr_ready || redir)) m_bv = 1'b0;
    if (old_bv && redir) m_cnt++;
    if (resp) begin
      e = pend.pop_front();
      if (e.stale || redir) m_cnt++;
      else begin
        m_bv  = 1'b1;
        m_bi  = bus.imem_rdata;
        m_bpc = e.pc;
      end
    end else if (redir && pend.size() > 0) begin
      e = pend[0];
      e.stale = 1'b1;
      pend[0] = e;
    end
    if (e_req && bus.imem_gnt) pend.push_back('{pc: bus.pc_in, stale: 1'b0});
    if (e_tb)          pc_reg = e_bt;
    else if (!e_stall) pc_reg = pc_reg + 32'd4;
  endtask

  // One cycle: compare all outputs against the model, advance the model on
  // the clock edge, present the new PC at the falling edge.
  task automatic step();
    #1;
    predict();
    check("imem_req",    32'(bus.imem_req),    32'(e_req));
    check("stallF",      32'(bus.stallF),      32'(e_stall));
    check("take_branch", 32'(bus.take_branch), 32'(e_tb));
    if (e_tb)  check("branch_target", bus.branch_target, e_bt);
    if (e_req) check("imem_addr",     bus.imem_addr,     bus.pc_in);
    check("instr_valid", 32'(bus.instr_valid), 32'(m_bv));
    check("instr",       bus.instr,            m_bi);
    check("instr_pc",    bus.instr_pc,         m_bpc);
    check("squash_cnt",  32'(bus.squash_cnt),  32'(m_cnt));
    @(posedge clk);
    if (rst) model_reset();
    else     model_update();
    @(negedge clk);
    bus.pc_in = pc_reg;
  endtask

  task automatic drive(input bit redir, input logic [31:0] tgt, input bit gnt,
                       input bit rvalid, input logic [31:0] rdata, input bit ready);
    bus.redirect_valid  = redir;
    bus.redirect_target = tgt;
    bus.imem_gnt        = gnt;
    bus.imem_rvalid     = rvalid;
    bus.imem_rdata      = rdata;
    bus.instr_ready     = ready;
  endtask

  initial begin
    rst    = 1'b1;
    pc_reg = '0;
    bus.pc_in = '0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // ---- straight-line fetch, one instruction every 2 cycles ----
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 1, pend.size() > 0, 32'h0000_0013, 1);
      #1;
      if (c == 0) begin
        check("A0 req",   32'(bus.imem_req), 1);
        check("A0 addr",  bus.imem_addr,     32'h0);
        check("A0 stall", 32'(bus.stallF),   0);
      end
      if (c == 1) begin
        check("A1 req",   32'(bus.imem_req), 0);
        check("A1 stall", 32'(bus.stallF),   1);
      end
      if (c == 2) begin
        check("A2 valid", 32'(bus.instr_valid), 1);
        check("A2 pc",    bus.instr_pc,         32'h0);
        check("A2 instr", bus.instr,            32'h13);
        check("A2 addr",  bus.imem_addr,        32'h4);
      end
      if (c == 4) check("A4 pc", bus.instr_pc, 32'h4);
      step();
    end
    check("A6 pc", bus.instr_pc, 32'h8);

    // ---- decode stall: buffer full, no request, outputs held ----
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 1, 0, 0, 0);
      #1;
      check("B req",   32'(bus.imem_req), 0);
      check("B stall", 32'(bus.stallF),   1);
      check("B pc",    bus.instr_pc,      32'h8);
      check("B instr", bus.instr,         32'h13);
      step();
    end
    drive(0, 0, 1, 0, 0, 1);
    #1;
    check("B resume req",  32'(bus.imem_req), 1);
    check("B resume addr", bus.imem_addr,     32'hC);
    step();

    // ---- redirect while waiting; stale response 3 cycles later ----
    drive(1, 32'h100, 1, 0, 0, 1);
    #1;
    check("C take_branch", 32'(bus.take_branch), 1);
    check("C target",      bus.branch_target,     32'h100);
    check("C stall",       32'(bus.stallF),       0);
    step();
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 1, 0, 0, 1);
      #1;
      check("C wait req", 32'(bus.imem_req), 0);
      step();
    end
    drive(0, 0, 1, 1, 32'hDEAD_BEEF, 1);
    step();
    drive(0, 0, 1, 0, 0, 1);
    #1;
    check("C valid", 32'(bus.instr_valid), 0);
    check("C cnt",   32'(bus.squash_cnt),  1);
    check("C req",   32'(bus.imem_req),    1);
    check("C addr",  bus.imem_addr,        32'h100);
    step();

    // ---- redirect coinciding with the response ----
    drive(1, 32'h202, 1, 1, 32'hBAD0_0BAD, 1);
    #1;
    check("D target", bus.branch_target, 32'h200);
    step();
    drive(0, 0, 1, 0, 0, 1);
    #1;
    check("D valid", 32'(bus.instr_valid), 0);
    check("D cnt",   32'(bus.squash_cnt),  2);
    check("D addr",  bus.imem_addr,        32'h200);
    step();
    drive(0, 0, 1, 1, 32'h0000_0ACE, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("D load valid", 32'(bus.instr_valid), 1);
    check("D load pc",    bus.instr_pc,         32'h200);
    check("D load instr", bus.instr,            32'hACE);

    // ---- redirect flushes a held instruction ----
    drive(1, 32'h300, 1, 0, 0, 0);
    #1;
    check("E req", 32'(bus.imem_req), 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("E valid", 32'(bus.instr_valid), 0);
    check("E cnt",   32'(bus.squash_cnt),  3);
    step();

    // ---- reset in S_WAIT, late response afterwards ----
    drive(0, 0, 1, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("F req",   32'(bus.imem_req),    0);
    check("F stall", 32'(bus.stallF),      1);
    check("F tb",    32'(bus.take_branch), 0);
    check("F cnt",   32'(bus.squash_cnt),  0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 1, 32'h5555_5555, 1);
    step();
    drive(0, 0, 0, 0, 0, 1);
    #1;
    check("F late valid", 32'(bus.instr_valid), 0);
    step();

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 3) != 0,
            (pend.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0),
            $urandom, $urandom_range(0, 9) < 7);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage sequencer that drives the program-counter register's control inputs (redirect request, redirect target, fetch stall) and the instruction-memory request/response handshake.
- Keeps at most one instruction-memory request outstanding and holds one fetched instruction in an output register for decode.
- Flushes fetched instructions and discards stale responses when execute redirects the PC.
- Counts squashed fetches for performance monitoring.

Parameters:
- XLEN, 32, width of addresses and instruction data.
- CNT_W, 16, width of the squash counter; the counter wraps.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- pc_in  in  XLEN  current PC from the PC register.
- take_branch  out  1  PC redirect strobe to the PC register.
- branch_target  out  XLEN  redirect target to the PC register.
- stallF  out  1  PC hold to the PC register; PC updates only when this is 0.
- redirect_valid  in  1  redirect request from execute, single-cycle pulse.
- redirect_target  in  XLEN  redirect address from execute.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  XLEN  request address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  XLEN  response instruction.
- instr_valid  out  1  output register holds a valid instruction.
- instr  out  XLEN  fetched instruction.
- instr_pc  out  XLEN  PC of the fetched instruction.
- instr_ready  in  1  decode consumes the instruction this cycle.
- squash_cnt  out  CNT_W  count of discarded fetches.

Behaviour:
- Reset values: state=S_REQ; instr_valid=0; instr=0; instr_pc=0; drop=0; squash_cnt=0; req_pc=0.
- Reset is asynchronous, may assert at any time, and returns to S_REQ. A response arriving in S_REQ is ignored, which covers late responses after reset.
- Outputs while rst=1: imem_req=0, stallF=1, take_branch=0.
- Buffer free condition: buf_free = !instr_valid | instr_ready.

S_REQ:
- imem_req = buf_free & !redirect_valid.
- imem_addr = pc_in.
- Accept = imem_req & imem_gnt.
  - On accept: stallF=0, so the PC advances to PC+4; req_pc<=pc_in; next state S_WAIT.
  - Otherwise: stallF=1 and the state stays S_REQ.

S_WAIT:
- imem_req=0; stallF=1 unless a redirect is active.
- On imem_rvalid & !drop: instr<=imem_rdata, instr_pc<=req_pc, instr_valid<=1; next state S_REQ.
- On imem_rvalid & drop: discard the response; drop<=0; squash_cnt+1; next state S_REQ.

Consumption:
- instr_valid & instr_ready clears instr_valid, unless a load happens the same cycle; the load wins.
- instr, instr, instr_pc are held stable while instr_valid & !instr_ready.
- Only one request is ever outstanding and it is issued only when buf_free, so a response never finds the buffer occupied.

Redirect (redirect_valid=1, any state):
- Combinational outputs that cycle: take_branch=1; branch_target={redirect_target[XLEN-1:2],2'b00}; stallF=0, so the PC loads the target next edge.
- If instr_valid=1: instr_valid<=0 and squash_cnt+1.
- S_REQ: no request is issued that cycle; the state stays S_REQ.
- S_WAIT without imem_rvalid: drop<=1 and the state stays S_WAIT.
- S_WAIT with imem_rvalid the same cycle: discard the response; squash_cnt+1; next state S_REQ; drop stays 0.
- A second redirect while drop=1 keeps drop=1; only one stale response is outstanding.
- squash_cnt increases by the number of discard events in a cycle, at most 2 per cycle (buffer flush plus response drop).
- Latency: without stalls, an instruction is fetched every 2 cycles (request, response). The first instruction after a redirect is requested in the cycle after the redirect.

Test Plan:
- Reset release, pc_in=0x0, imem_gnt=1, rvalid one cycle after each grant returning 0x00000013, instr_ready=1: imem_req is high at cycle 0 with addr 0x0. Then instr_valid=1 with instr_pc=0x0, next 0x4, then 0x8, one every 2 cycles; stallF is 0 only on grant cycles.
- Decode stall: instr_ready=0 with instr_valid=1 for 5 cycles: no imem_req, instr and instr_pc held constant, stallF=1. After instr_ready=1 the next request issues the same cycle.
- Redirect during S_WAIT to 0x100, response arriving 3 cycles later: take_branch=1 and branch_target=0x100 in the redirect cycle, and the stale response is not presented. squash_cnt increments by 1 for the dropped response, plus 1 more if the buffer held a valid instruction at the redirect. The next request has addr 0x100.
- Redirect coinciding with imem_rvalid, target 0x202: branch_target=0x200, the response is discarded, the state is S_REQ next cycle with drop=0, and the following request has addr 0x200.
- Redirect with instr_valid=1 and instr_ready=0: instr_valid=0 next cycle and squash_cnt+1.
- Assert rst during S_WAIT, then pulse imem_rvalid after release while still in S_REQ: all outputs return to reset values immediately, and the late response is ignored (instr_valid stays 0).
